yuv_raster_parser: RTL and testbench
====================================

Name: yuv_raster_parser

Overview:
- Consumes the raw planar YUV 4:2:0 byte stream delivered by the file-playback bench: one byte per clock, CIF by default, frames back to back.
- Tags each byte with its plane, x/y coordinate and frame/line markers, and counts frames.
- Sits directly downstream of the stream source and feeds all later encoder stages, which rely on its coordinates instead of counting bytes themselves.

Parameters:
- FRAME_W, 352, luma width in pixels; must be even and >= 2.
- FRAME_H, 288, luma height in lines; must be even and >= 2.
- CW, 9, coordinate width in bits; must satisfy 2^CW >= max(FRAME_W, FRAME_H).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a stream byte this cycle.
- in_data  input  8  stream byte.
- resync  input  1  force frame alignment: the next accepted byte is the first Y byte of a new frame.
- pix_valid  output  1  output byte valid.
- pix_data  output  8  registered copy of in_data.
- pix_plane  output  2  plane tag: 0 = Y, 1 = U, 2 = V; 3 never driven.
- pix_x  output  CW  column within the current plane.
- pix_y  output  CW  row within the current plane.
- pix_sof  output  1  first Y byte of a frame (x=0, y=0).
- pix_eol  output  1  last byte of a row in any plane.
- pix_eof  output  1  last V byte of a frame.
- frame_cnt  output  16  number of completed frames.

Behaviour:
- Reset: all outputs 0; state PLANE_Y; x, y cleared; resync_pending cleared. Reset takes effect immediately, including mid-frame.
- State machine:
  - PLANE_Y: FRAME_W x FRAME_H bytes.
  - PLANE_U: (FRAME_W/2) x (FRAME_H/2) bytes.
  - PLANE_V: same size as U.
  - Order is Y -> U -> V -> Y.
  - Current plane dimensions are w = FRAME_W, h = FRAME_H in Y, and FRAME_W/2, FRAME_H/2 in U/V.
- Latency: exactly 1 cycle. A byte accepted at edge N appears on pix_* after edge N, alongside the tags computed from the state before edge N.
- pix_valid is a registered copy of in_valid. When in_valid=0: counters and state hold, pix_valid=0, and pix_data/pix_plane/pix_x/pix_y hold their last values. pix_sof, pix_eol and pix_eof are 0 whenever pix_valid=0.
- Per accepted byte:
  - If x == w-1: x <= 0 and pix_eol=1. Then, if y == h-1: y <= 0 and plane advances; otherwise y <= y+1.
  - Otherwise x <= x+1.
- pix_eof = 1 on the byte with plane V, x = FRAME_W/2-1, y = FRAME_H/2-1.
- frame_cnt increments by 1 in the same cycle pix_eof is asserted (visible alongside it) and wraps 0xFFFF -> 0.
- pix_sof = 1 on every byte tagged plane Y, x=0, y=0. This includes the first byte after reset or after a resync.
- resync:
  - Asserted without in_valid: sets resync_pending. The next valid byte is tagged Y,0,0 with sof, then counting continues from there.
  - Asserted together with in_valid: that same byte is treated as Y,0,0.
  - The truncated frame does not increment frame_cnt and produces no eof.
  - resync_pending clears on the first valid byte it applies to.
- Arithmetic: unsigned; no overflow is possible on x/y given the CW constraint.

Test Plan:
- Reset mid-stream (use FRAME_W=4, FRAME_H=2 for this test; frame = 8 Y + 2 U + 2 V = 12 bytes): assert rst after 5 bytes -> all outputs 0 immediately; first byte after release tagged plane 0, x0, y0, sof=1.
- Continuous stream 0x00..0x17 (two frames) with FRAME_W=4, FRAME_H=2:
  - byte 0x03 -> (Y, 3, 0) eol.
  - byte 0x08 -> (U, 0, 0).
  - byte 0x0B -> (V, 1, 0) eol, eof, frame_cnt=1.
  - byte 0x0C -> sof.
  - after byte 0x17 -> frame_cnt=2.
- in_valid gaps (valid every 3rd cycle) over one frame -> identical tag sequence to the continuous case; pix_valid=0 and markers 0 in gap cycles; frame_cnt=1.
- resync (FRAME_W=4, FRAME_H=2): pulse resync alone after byte 5, then send byte 0xAA -> 0xAA tagged (Y, 0, 0) sof; frame_cnt unchanged at 0. Repeat with resync coincident with in_valid -> same result.
- Default CIF, 152064 bytes -> eof exactly on byte 152063 with (V, 175, 143); 288+144+144 = 576 eol pulses; frame_cnt=1.
- frame_cnt wrap (FRAME_W=4, FRAME_H=2): force frame_cnt to 0xFFFF, then stream one frame -> wraps to 0x0000 on eof.

Source files
------------

// File: rtl/yuv_raster_parser.sv
// Tags each byte of a planar YUV 4:2:0 stream with plane, x/y position and frame/line markers.
// One cycle of latency. Frames repeat Y -> U -> V back to back, and frame_cnt counts completed frames.
module yuv_raster_parser #(
    parameter int FRAME_W = 352,
    parameter int FRAME_H = 288,
    parameter int CW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          resync,
    output logic          pix_valid,
    output logic [7:0]    pix_data,
    output logic [1:0]    pix_plane,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic [15:0]   frame_cnt
);

    localparam logic [1:0] PLANE_Y = 2'd0;
    localparam logic [1:0] PLANE_U = 2'd1;
    localparam logic [1:0] PLANE_V = 2'd2;

    localparam logic [CW-1:0] Y_LAST_X = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] Y_LAST_Y = CW'(FRAME_H - 1);
    localparam logic [CW-1:0] C_LAST_X = CW'(FRAME_W / 2 - 1);
    localparam logic [CW-1:0] C_LAST_Y = CW'(FRAME_H / 2 - 1);

    logic [1:0]    plane_reg;
    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;
    logic          resync_pending_reg;
    logic [15:0]   frame_cnt_reg;

    logic          start_frame;
    logic [1:0]    cur_plane;
    logic [CW-1:0] cur_x;
    logic [CW-1:0] cur_y;
    logic [CW-1:0] last_x;
    logic [CW-1:0] last_y;
    logic          row_end;
    logic          plane_end;
    logic          frame_end;
    logic          sof_next;
    logic [1:0]    plane_next;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;

    // A pending or coincident resync overrides the stored position with Y,0,0.
    always_comb begin
        start_frame = resync | resync_pending_reg;
        cur_plane   = start_frame ? PLANE_Y : plane_reg;
        cur_x       = start_frame ? '0 : x_reg;
        cur_y       = start_frame ? '0 : y_reg;

        last_x = (cur_plane == PLANE_Y) ? Y_LAST_X : C_LAST_X;
        last_y = (cur_plane == PLANE_Y) ? Y_LAST_Y : C_LAST_Y;

        row_end   = (cur_x == last_x);
        plane_end = row_end && (cur_y == last_y);
        frame_end = plane_end && (cur_plane == PLANE_V);
        sof_next  = (cur_plane == PLANE_Y) && (cur_x == '0) && (cur_y == '0);

        plane_next = cur_plane;
        if (plane_end) begin
            case (cur_plane)
                PLANE_Y: plane_next = PLANE_U;
                PLANE_U: plane_next = PLANE_V;
                default: plane_next = PLANE_Y;
            endcase
        end

        x_next = row_end ? '0 : cur_x + 1'b1;
        y_next = cur_y;
        if (row_end) begin
            y_next = plane_end ? '0 : cur_y + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plane_reg          <= PLANE_Y;
            x_reg              <= '0;
            y_reg              <= '0;
            resync_pending_reg <= 1'b0;
            frame_cnt_reg      <= '0;
            pix_valid          <= 1'b0;
            pix_data           <= '0;
            pix_plane          <= '0;
            pix_x              <= '0;
            pix_y              <= '0;
            pix_sof            <= 1'b0;
            pix_eol            <= 1'b0;
            pix_eof            <= 1'b0;
        end else if (in_valid) begin
            plane_reg          <= plane_next;
            x_reg              <= x_next;
            y_reg              <= y_next;
            resync_pending_reg <= 1'b0;
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            pix_valid <= 1'b1;
            pix_data  <= in_data;
            pix_plane <= cur_plane;
            pix_x     <= cur_x;
            pix_y     <= cur_y;
            pix_sof   <= sof_next;
            pix_eol   <= row_end;
            pix_eof   <= frame_end;
        end else begin
            // Idle cycle: position holds, tags hold, markers drop.
            resync_pending_reg <= resync_pending_reg | resync;
            pix_valid          <= 1'b0;
            pix_sof            <= 1'b0;
            pix_eol            <= 1'b0;
            pix_eof            <= 1'b0;
        end
    end

    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_yuv_raster_parser.sv
// Drives a tiny 4x2 parser and a mid-size 22x18 parser with the same byte stream.
// Both are compared every cycle against a byte-index reference model.
module tb_yuv_raster_parser;

    localparam int AW = 4, AH = 2, ACW = 3;
    localparam int BW = 22, BH = 18, BCW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic resync = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic a_valid, a_sof, a_eol, a_eof;
    logic [7:0] a_data;
    logic [1:0] a_plane;
    logic [ACW-1:0] a_x, a_y;
    logic [15:0] a_frame_cnt;

    logic b_valid, b_sof, b_eol, b_eof;
    logic [7:0] b_data;
    logic [1:0] b_plane;
    logic [BCW-1:0] b_x, b_y;
    logic [15:0] b_frame_cnt;

    yuv_raster_parser #(.FRAME_W(AW), .FRAME_H(AH), .CW(ACW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .resync(resync),
        .pix_valid(a_valid), .pix_data(a_data), .pix_plane(a_plane), .pix_x(a_x), .pix_y(a_y),
        .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof), .frame_cnt(a_frame_cnt)
    );

    yuv_raster_parser #(.FRAME_W(BW), .FRAME_H(BH), .CW(BCW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .resync(resync),
        .pix_valid(b_valid), .pix_data(b_data), .pix_plane(b_plane), .pix_x(b_x), .pix_y(b_y),
        .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof), .frame_cnt(b_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_equal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position is a byte index within the frame; tags come from division.
    int          m_w[2] = '{AW, BW};
    int          m_h[2] = '{AH, BH};
    int          m_idx[2];
    logic        m_pend[2];
    logic [15:0] m_fcnt[2];
    logic        e_valid[2], e_sof[2], e_eol[2], e_eof[2];
    logic [7:0]  e_data[2];
    int          e_plane[2], e_x[2], e_y[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = 0; m_pend[i] = 1'b0; m_fcnt[i] = 16'd0;
            e_valid[i] = 1'b0; e_sof[i] = 1'b0; e_eol[i] = 1'b0; e_eof[i] = 1'b0;
            e_data[i] = 8'h00; e_plane[i] = 0; e_x[i] = 0; e_y[i] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic rs);
        for (int i = 0; i < 2; i++) begin
            int ysz, csz, fsz, off, pw;
            ysz = m_w[i] * m_h[i];
            csz = ysz / 4;
            fsz = ysz + 2 * csz;
            if (!v) begin
                if (rs) m_pend[i] = 1'b1;
                e_valid[i] = 1'b0; e_sof[i] = 1'b0; e_eol[i] = 1'b0; e_eof[i] = 1'b0;
            end else begin
                if (rs || m_pend[i]) m_idx[i] = 0;
                m_pend[i] = 1'b0;
                if (m_idx[i] < ysz) begin
                    e_plane[i] = 0; off = m_idx[i]; pw = m_w[i];
                end else if (m_idx[i] < ysz + csz) begin
                    e_plane[i] = 1; off = m_idx[i] - ysz; pw = m_w[i] / 2;
                end else begin
                    e_plane[i] = 2; off = m_idx[i] - ysz - csz; pw = m_w[i] / 2;
                end
                e_valid[i] = 1'b1;
                e_data[i]  = d;
                e_x[i]     = off % pw;
                e_y[i]     = off / pw;
                e_sof[i]   = (m_idx[i] == 0);
                e_eol[i]   = (e_x[i] == pw - 1);
                e_eof[i]   = (m_idx[i] == fsz - 1);
                if (e_eof[i]) m_fcnt[i] = m_fcnt[i] + 16'd1;
                m_idx[i] = (m_idx[i] + 1) % fsz;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "A" : "B";
            check_equal({p, ".pix_valid"}, (i == 0) ? 32'(a_valid) : 32'(b_valid), 32'(e_valid[i]));
            check_equal({p, ".pix_data"},  (i == 0) ? 32'(a_data)  : 32'(b_data),  32'(e_data[i]));
            check_equal({p, ".pix_plane"}, (i == 0) ? 32'(a_plane) : 32'(b_plane), 32'(e_plane[i]));
            check_equal({p, ".pix_x"},     (i == 0) ? 32'(a_x)     : 32'(b_x),     32'(e_x[i]));
            check_equal({p, ".pix_y"},     (i == 0) ? 32'(a_y)     : 32'(b_y),     32'(e_y[i]));
            check_equal({p, ".pix_sof"},   (i == 0) ? 32'(a_sof)   : 32'(b_sof),   32'(e_sof[i]));
            check_equal({p, ".pix_eol"},   (i == 0) ? 32'(a_eol)   : 32'(b_eol),   32'(e_eol[i]));
            check_equal({p, ".pix_eof"},   (i == 0) ? 32'(a_eof)   : 32'(b_eof),   32'(e_eof[i]));
            check_equal({p, ".frame_cnt"}, (i == 0) ? 32'(a_frame_cnt) : 32'(b_frame_cnt), 32'(m_fcnt[i]));
        end
    endtask

    // Called one time unit after a rising edge; samples one time unit after the next.
    task automatic drive(input logic v, input logic [7:0] d, input logic rs);
        in_valid = v; in_data = d; resync = rs;
        model_step(v, d, rs);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        resync = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int eol_cnt, eof_at;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        $display("test: reset mid-stream");
        for (int b = 0; b < 5; b++) drive(1'b1, 8'(b), 1'b0);
        do_reset();
        drive(1'b1, 8'h55, 1'b0);
        check_equal("rst.first_plane", 32'(a_plane), 32'd0);
        check_equal("rst.first_x", 32'(a_x), 32'd0);
        check_equal("rst.first_sof", 32'(a_sof), 32'd1);

        $display("test: continuous two frames");
        do_reset();
        for (int b = 0; b < 24; b++) begin
            drive(1'b1, 8'(b), 1'b0);
            if (b == 3) begin
                check_equal("cont.b03_plane", 32'(a_plane), 32'd0);
                check_equal("cont.b03_x", 32'(a_x), 32'd3);
                check_equal("cont.b03_eol", 32'(a_eol), 32'd1);
            end
            if (b == 8) begin
                check_equal("cont.b08_plane", 32'(a_plane), 32'd1);
                check_equal("cont.b08_x", 32'(a_x), 32'd0);
            end
            if (b == 11) begin
                check_equal("cont.b0b_plane", 32'(a_plane), 32'd2);
                check_equal("cont.b0b_x", 32'(a_x), 32'd1);
                check_equal("cont.b0b_eof", 32'(a_eof), 32'd1);
                check_equal("cont.b0b_fcnt", 32'(a_frame_cnt), 32'd1);
            end
            if (b == 12) check_equal("cont.b0c_sof", 32'(a_sof), 32'd1);
        end
        check_equal("cont.final_fcnt", 32'(a_frame_cnt), 32'd2);

        $display("test: valid every third cycle");
        do_reset();
        for (int b = 0; b < 12; b++) begin
            drive(1'b1, 8'(b), 1'b0);
            drive(1'b0, 8'($urandom), 1'b0);
            drive(1'b0, 8'($urandom), 1'b0);
        end
        check_equal("gap.fcnt", 32'(a_frame_cnt), 32'd1);

        $display("test: resync alone and coincident");
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            for (int b = 0; b < 6; b++) drive(1'b1, 8'(b), 1'b0);
            if (mode == 0) begin
                drive(1'b0, 8'h00, 1'b1);
                drive(1'b1, 8'hAA, 1'b0);
            end else begin
                drive(1'b1, 8'hAA, 1'b1);
            end
            check_equal("resync.data", 32'(a_data), 32'hAA);
            check_equal("resync.plane", 32'(a_plane), 32'd0);
            check_equal("resync.x", 32'(a_x), 32'd0);
            check_equal("resync.y", 32'(a_y), 32'd0);
            check_equal("resync.sof", 32'(a_sof), 32'd1);
            check_equal("resync.fcnt", 32'(a_frame_cnt), 32'd0);
            for (int b = 0; b < 12; b++) drive(1'b1, 8'($urandom), 1'b0);
        end

        $display("test: frame_cnt wrap");
        do_reset();
        force dut_a.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut_a.frame_cnt_reg;
        m_fcnt[0] = 16'hFFFF;
        check_equal("wrap.preset", 32'(a_frame_cnt), 32'hFFFF);
        for (int b = 0; b < 12; b++) drive(1'b1, 8'(b), 1'b0);
        check_equal("wrap.after", 32'(a_frame_cnt), 32'h0000);

        $display("test: full 22x18 frame");
        do_reset();
        eol_cnt = 0;
        eof_at = -1;
        for (int k = 0; k < BW * BH * 3 / 2; k++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            if (b_eol) eol_cnt++;
            if (b_eof) begin
                eof_at = k;
                check_equal("full.eof_plane", 32'(b_plane), 32'd2);
                check_equal("full.eof_x", 32'(b_x), 32'(BW / 2 - 1));
                check_equal("full.eof_y", 32'(b_y), 32'(BH / 2 - 1));
            end
        end
        check_equal("full.eol_count", 32'(eol_cnt), 32'(BH + BH / 2 + BH / 2));
        check_equal("full.eof_index", 32'(eof_at), 32'(BW * BH * 3 / 2 - 1));
        check_equal("full.fcnt", 32'(b_frame_cnt), 32'd1);

        $display("test: random valid/resync stream");
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            drive(1'($urandom_range(0, 99) < 70), 8'($urandom), 1'($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
